sram_arbiter: RTL and testbench
===============================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameters: none; all widths fixed as listed below.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low; sampled on rising edge of clk.
REQ-004 i_read_en  input  1  instruction-fetch read request, held high until i_ready.
REQ-005 i_addr  input  32  instruction-fetch byte address.
REQ-006 i_rdata  output  64  instruction-fetch read data, valid only while i_ready=1.
REQ-007 i_ready  output  1  instruction-fetch transaction complete.
REQ-008 m_read_en  input  1  memory-stage (cache controller) read request, held until m_ready.
REQ-009 m_write_en  input  1  memory-stage write request, held until m_ready.
REQ-010 m_addr  input  32  memory-stage byte address.
REQ-011 m_wdata  input  32  memory-stage store value.
REQ-012 m_rdata  output  64  memory-stage read data, valid only while m_ready=1.
REQ-013 m_ready  output  1  memory-stage transaction complete.
REQ-014 sram_read_en  output  1  read command to SRAM controller.
REQ-015 sram_write_en  output  1  write command to SRAM controller.
REQ-016 sram_addr  output  32  address to SRAM controller.
REQ-017 sram_write_data  output  32  store value to SRAM controller.
REQ-018 sram_read_data  input  64  read data from SRAM controller.
REQ-019 sram_ready  input  1  SRAM controller completion, one-cycle pulse.
REQ-020 conflict_cnt  output  16  count of IDLE cycles with both requesters pending, saturating.

Function
REQ-021 FSM states SHALL be IDLE, SERVE_I, SERVE_M; at most one requester owns the SRAM controller at any time.
REQ-022 Request definitions: i_req = i_read_en; m_req = m_read_en | m_write_en.
REQ-023 In IDLE with exactly one request, that requester SHALL be granted at the next edge.
REQ-024 In IDLE with both requests, the requester not granted last SHALL be granted (round-robin); last_owner resets to I, so MEM wins the first tie.
REQ-025 On grant, the owner's address, write data and command SHALL be latched; requester changes during SERVE_x SHALL be ignored.
REQ-026 If m_read_en and m_write_en are both high at grant, the transaction SHALL be a write.
REQ-027 sram_* outputs SHALL be registered: asserted from the first SERVE_x cycle and held constant until sram_ready.
REQ-028 In SERVE_x with sram_ready=1: x_ready=1 and x_rdata=sram_read_data combinationally in that same cycle; FSM returns to IDLE at the next edge with sram enables low.
REQ-029 Minimum spacing: request sampled at edge N -> enables high after N; completion cycle -> IDLE one cycle -> next grant earliest one cycle later.
REQ-030 x_ready SHALL be 0 and x_rdata SHALL be 0 whenever x is not the owner or sram_ready=0.
REQ-031 A requester with no owning grant SHALL see no ready; a request dropped before grant SHALL be discarded.
REQ-032 sram_ready in IDLE SHALL be ignored; no ready output and no state change.
REQ-033 conflict_cnt SHALL increment by 1 in each IDLE cycle with i_req & m_req and hold at 16'hFFFF.
REQ-034 Non-owner starvation bound: under continuous requests from both, grants SHALL alternate I/M strictly.

Reset
REQ-035 rst=0 at an edge SHALL force: state IDLE, last_owner=I, all sram_* outputs 0, conflict_cnt 0. i_ready, m_ready, i_rdata and m_rdata are then 0 because state is IDLE.
REQ-036 Reset mid-transaction SHALL abort without any ready pulse; a pending sram_ready in that cycle is ignored.

Verification
REQ-037 Single IF read, addr 0x100, sram_ready 3 cycles after enable, read data 64'hA5 -> sram_read_en=1, sram_addr=0x100 for 3 cycles; i_ready=1 and i_rdata=64'hA5 in the sram_ready cycle; m_ready stays 0.
REQ-038 MEM write, addr 0x40, data 0xDEADBEEF -> sram_write_en=1, sram_write_data=0xDEADBEEF, sram_read_en=0; m_ready pulses once.
REQ-039 Simultaneous IF and MEM requests out of reset, both held -> grants in order M, I, M, I; conflict_cnt increments once per IDLE tie cycle.
REQ-040 During SERVE_M, m_addr changes 0x40 -> 0x80 -> sram_addr stays 0x40 until completion.
REQ-041 rst=0 two cycles into SERVE_I with sram_ready coincident -> no i_ready pulse; all outputs zero next cycle; state IDLE.
REQ-042 Saturation: force 70000 tie cycles -> conflict_cnt holds 16'hFFFF.

Source files
------------

// File: rtl/sram_arbiter.sv
// Round-robin arbiter that shares one SRAM controller between the instruction-fetch
// and memory-stage requesters, one transaction at a time.
module sram_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_read_en,
  input  logic [31:0] i_addr,
  output logic [63:0] i_rdata,
  output logic        i_ready,
  input  logic        m_read_en,
  input  logic        m_write_en,
  input  logic [31:0] m_addr,
  input  logic [31:0] m_wdata,
  output logic [63:0] m_rdata,
  output logic        m_ready,
  output logic        sram_read_en,
  output logic        sram_write_en,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_write_data,
  input  logic [63:0] sram_read_data,
  input  logic        sram_ready,
  output logic [15:0] conflict_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_M = 2'd2
  } state_t;

  state_t state;
  logic   last_m;
  logic   i_req;
  logic   m_req;

  assign i_req = i_read_en;
  assign m_req = m_read_en | m_write_en;

  // Arbitration FSM; the SRAM command is latched at grant and held until completion.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state           <= IDLE;
      last_m          <= 1'b0;
      sram_read_en    <= 1'b0;
      sram_write_en   <= 1'b0;
      sram_addr       <= 32'h0;
      sram_write_data <= 32'h0;
      conflict_cnt    <= 16'h0;
    end else begin
      case (state)
        IDLE: begin
          if (i_req && m_req && (conflict_cnt != 16'hFFFF)) begin
            conflict_cnt <= conflict_cnt + 16'd1;
          end
          // On a tie, memory wins unless it was the previous owner.
          if (m_req && (!i_req || !last_m)) begin
            state           <= SERVE_M;
            last_m          <= 1'b1;
            sram_read_en    <= ~m_write_en;
            sram_write_en   <= m_write_en;
            sram_addr       <= m_addr;
            sram_write_data <= m_wdata;
          end else if (i_req) begin
            state           <= SERVE_I;
            last_m          <= 1'b0;
            sram_read_en    <= 1'b1;
            sram_write_en   <= 1'b0;
            sram_addr       <= i_addr;
            sram_write_data <= 32'h0;
          end else begin
            state <= IDLE;
          end
        end
        SERVE_I, SERVE_M: begin
          if (sram_ready) begin
            state           <= IDLE;
            sram_read_en    <= 1'b0;
            sram_write_en   <= 1'b0;
            sram_addr       <= 32'h0;
            sram_write_data <= 32'h0;
          end else begin
            state <= state;
          end
        end
        default: begin
          state           <= IDLE;
          sram_read_en    <= 1'b0;
          sram_write_en   <= 1'b0;
          sram_addr       <= 32'h0;
          sram_write_data <= 32'h0;
        end
      endcase
    end
  end

  // Completion is steered to the owner in the same cycle; a reset cycle suppresses it.
  always_comb begin
    i_ready = 1'b0;
    m_ready = 1'b0;
    i_rdata = 64'h0;
    m_rdata = 64'h0;
    if (rst && sram_ready && (state == SERVE_I)) begin
      i_ready = 1'b1;
      i_rdata = sram_read_data;
    end else if (rst && sram_ready && (state == SERVE_M)) begin
      m_ready = 1'b1;
      m_rdata = sram_read_data;
    end else begin
      i_ready = 1'b0;
      m_ready = 1'b0;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: transaction-level reference model checked every
// cycle, plus hand-computed expectations for the key scenarios.
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_read_en;
  logic [31:0] i_addr;
  logic [63:0] i_rdata;
  logic        i_ready;
  logic        m_read_en;
  logic        m_write_en;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [63:0] m_rdata;
  logic        m_ready;
  logic        sram_read_en;
  logic        sram_write_en;
  logic [31:0] sram_addr;
  logic [31:0] sram_write_data;
  logic [63:0] sram_read_data;
  logic        sram_ready;
  logic [15:0] conflict_cnt;

  sram_arbiter dut (
    .clk(clk), .rst(rst),
    .i_read_en(i_read_en), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .m_read_en(m_read_en), .m_write_en(m_write_en), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_rdata(m_rdata), .m_ready(m_ready),
    .sram_read_en(sram_read_en), .sram_write_en(sram_write_en),
    .sram_addr(sram_addr), .sram_write_data(sram_write_data),
    .sram_read_data(sram_read_data), .sram_ready(sram_ready),
    .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit model_on = 1'b0;

  // Reference model: who owns the SRAM (0 none, 1 IF, 2 MEM) and the latched command.
  int          own;
  bit          last_was_m;
  bit          e_rd, e_wr;
  logic [31:0] e_addr, e_wd;
  int          e_cnt;
  int          winner;
  bit          ir, mr;

  int          m_pulses = 0;
  logic [31:0] grant_log[$];
  bit          prev_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors < 40) $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (!rst) begin
      own = 0; last_was_m = 1'b0; e_rd = 1'b0; e_wr = 1'b0;
      e_addr = 32'h0; e_wd = 32'h0; e_cnt = 0;
      model_on = 1'b1;
    end else if (own == 0) begin
      ir = i_read_en;
      mr = m_read_en | m_write_en;
      if (ir && mr) e_cnt = (e_cnt < 65535) ? e_cnt + 1 : 65535;
      winner = (ir && mr) ? (last_was_m ? 1 : 2) : (mr ? 2 : (ir ? 1 : 0));
      if (winner == 1) begin
        own = 1; last_was_m = 1'b0; e_rd = 1'b1; e_wr = 1'b0; e_addr = i_addr; e_wd = 32'h0;
      end else if (winner == 2) begin
        own = 2; last_was_m = 1'b1; e_wr = m_write_en; e_rd = !m_write_en;
        e_addr = m_addr; e_wd = m_wdata;
      end
    end else if (sram_ready) begin
      own = 0; e_rd = 1'b0; e_wr = 1'b0; e_addr = 32'h0; e_wd = 32'h0;
    end
  end

  // Every cycle compare against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (model_on) begin
      chk("sram_read_en", sram_read_en, e_rd);
      chk("sram_write_en", sram_write_en, e_wr);
      chk("sram_addr", sram_addr, e_addr);
      chk("sram_write_data", sram_write_data, e_wd);
      chk("conflict_cnt", conflict_cnt, e_cnt[15:0]);
      chk("i_ready", i_ready, rst && sram_ready && own == 1);
      chk("m_ready", m_ready, rst && sram_ready && own == 2);
      chk("i_rdata", i_rdata, (rst && sram_ready && own == 1) ? sram_read_data : 64'h0);
      chk("m_rdata", m_rdata, (rst && sram_ready && own == 2) ? sram_read_data : 64'h0);
    end
    if (m_ready === 1'b1) m_pulses++;
    if ((sram_read_en | sram_write_en) && !prev_en) grant_log.push_back(sram_addr);
    prev_en = sram_read_en | sram_write_en;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b0;
    tick; tick;
    rst = 1'b1;
  endtask

  // Waits (bounded) for a command, then completes it lat cycles after it appeared.
  task automatic respond(input int lat, input logic [63:0] data);
    int n = 0;
    while (!(sram_read_en | sram_write_en) && n < 20) begin
      tick; n++;
    end
    chk("grant_timeout", n < 20, 1'b1);
    repeat (lat - 1) tick;
    sram_ready = 1'b1; sram_read_data = data;
    tick;
    sram_ready = 1'b0; sram_read_data = 64'h0;
  endtask

  initial begin
    i_read_en = 1'b0; i_addr = 32'h0; m_read_en = 1'b0; m_write_en = 1'b0;
    m_addr = 32'h0; m_wdata = 32'h0; sram_read_data = 64'h0; sram_ready = 1'b0;
    do_reset;
    chk("reset_cnt", conflict_cnt, 16'h0);
    chk("reset_rd", sram_read_en, 1'b0);

    // Single fetch read, three-cycle latency.
    i_read_en = 1'b1; i_addr = 32'h100;
    tick;
    chk("if_rd_en", sram_read_en, 1'b1);
    chk("if_addr", sram_addr, 32'h100);
    tick; tick;
    chk("if_rd_en_c3", sram_read_en, 1'b1);
    sram_ready = 1'b1; sram_read_data = 64'hA5;
    #1;
    chk("if_ready", i_ready, 1'b1);
    chk("if_rdata", i_rdata, 64'hA5);
    chk("if_m_ready", m_ready, 1'b0);
    tick;
    sram_ready = 1'b0; sram_read_data = 64'h0; i_read_en = 1'b0;
    chk("if_done", sram_read_en, 1'b0);

    // Stray completion while idle must be ignored.
    sram_ready = 1'b1; #1;
    chk("idle_ready_i", i_ready, 1'b0);
    chk("idle_ready_m", m_ready, 1'b0);
    tick; sram_ready = 1'b0;

    // Memory write, with read enable also high: write wins.
    m_write_en = 1'b1; m_read_en = 1'b1; m_addr = 32'h40; m_wdata = 32'hDEADBEEF;
    tick;
    chk("mw_wr_en", sram_write_en, 1'b1);
    chk("mw_rd_en", sram_read_en, 1'b0);
    chk("mw_wdata", sram_write_data, 32'hDEADBEEF);
    respond(2, 64'h0);
    m_write_en = 1'b0; m_read_en = 1'b0;
    tick; tick;
    chk("mw_pulses", m_pulses, 1);

    // Address change during service is ignored.
    m_read_en = 1'b1; m_addr = 32'h40;
    tick;
    m_addr = 32'h80;
    tick;
    chk("m_addr_held", sram_addr, 32'h40);
    respond(2, 64'h1234_5678_9ABC_DEF0);
    m_read_en = 1'b0;
    tick;

    // Ties out of reset: M, I, M, I and one conflict per tie.
    do_reset;
    grant_log.delete();
    i_read_en = 1'b1; i_addr = 32'h200; m_read_en = 1'b1; m_addr = 32'h300;
    for (int k = 0; k < 4; k++) respond(1, 64'h10 + 64'(k));
    i_read_en = 1'b0; m_read_en = 1'b0;
    tick;
    chk("tie_cnt", conflict_cnt, 16'd4);
    chk("tie_ngrants", grant_log.size(), 4);
    if (grant_log.size() == 4) begin
      chk("tie_g0", grant_log[0], 32'h300);
      chk("tie_g1", grant_log[1], 32'h200);
      chk("tie_g2", grant_log[2], 32'h300);
      chk("tie_g3", grant_log[3], 32'h200);
    end

    // Reset two cycles into a fetch, with completion in the same cycle.
    i_read_en = 1'b1; i_addr = 32'h500;
    tick; tick;
    rst = 1'b0; sram_ready = 1'b1; sram_read_data = 64'hFF;
    #1;
    chk("abort_i_ready", i_ready, 1'b0);
    chk("abort_i_rdata", i_rdata, 64'h0);
    tick;
    rst = 1'b1; sram_ready = 1'b0; sram_read_data = 64'h0; i_read_en = 1'b0;
    chk("abort_rd", sram_read_en, 1'b0);
    chk("abort_addr", sram_addr, 32'h0);
    chk("abort_cnt", conflict_cnt, 16'h0);
    tick;

    // Saturation: enough back-to-back ties to pass the counter limit.
    i_read_en = 1'b1; m_read_en = 1'b1;
    for (int k = 0; k < 65540; k++) begin
      tick; sram_ready = 1'b1;
      tick; sram_ready = 1'b0;
    end
    i_read_en = 1'b0; m_read_en = 1'b0;
    tick;
    chk("sat_cnt", conflict_cnt, 16'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
